// File: rtl/p2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : p2s_pkg
// Purpose  : Shared constants and state encoding for the parallel-to-serial TX.
// Revision : 1.0 - initial release
// ============================================================================
package p2s_pkg;

    localparam int unsigned C_DATA_W     = 8;
    localparam logic [7:0]  C_IDLE_SYM   = 8'hBC;
    localparam int unsigned C_SYNC_BYTES = 4;

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        SYNC = ST_SYNC,
        RUN  = ST_RUN
    } p2s_state_t;

endpackage
`default_nettype wire

// File: rtl/par2serial_shreg.sv
`default_nettype none
// ============================================================================
// Module   : par2serial_shreg
// Purpose  : Loadable left-shift register; MSB is the serial output bit.
// Revision : 1.0 - initial release
// ============================================================================
module par2serial_shreg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_dout_msb
);

    logic [DATA_W-1:0] r_shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_din;
        end else begin
            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
        end
    end

    assign o_dout_msb = r_shreg[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/par2serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : par2serial_tx
// Purpose  : Serialises the mux byte stream MSB-first, preceded by idle sync
//            symbols after reset. Optional alignment checker: P2S_ERR_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module par2serial_tx
    import p2s_pkg::*;
#(
    parameter int unsigned       DATA_W     = C_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(C_IDLE_SYM),
    parameter int unsigned       SYNC_BYTES = C_SYNC_BYTES
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              data_out,
    output logic              frame_start,
    output logic              active
`ifdef P2S_ERR_CHK_EN
    ,
    output logic              err_align
`endif
);

    localparam int unsigned      CNT_W     = $clog2(DATA_W);
    localparam int unsigned      SYNC_W    = $clog2(SYNC_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BYTES - 1);

    logic [CNT_W-1:0]  r_bit_cnt;
    logic [SYNC_W-1:0] r_sync_cnt;
    p2s_state_t        r_state;
    logic              r_frame_start;
    logic              r_active;
    logic              w_load;
    logic [DATA_W-1:0] w_next_byte;

    assign w_load = (r_bit_cnt == LAST_BIT);

    // valid_in only matters once sync symbols have all gone out
    always_comb begin
        w_next_byte = IDLE_SYM;
        if (r_state == RUN && valid_in) begin
            w_next_byte = data_in;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_bit_cnt     <= LAST_BIT;
            r_frame_start <= 1'b0;
            r_active      <= 1'b0;
            r_sync_cnt    <= '0;
            r_state       <= SYNC;
        end else if (w_load) begin
            r_bit_cnt     <= '0;
            r_frame_start <= 1'b1;
            if (r_state == SYNC) begin
                r_active   <= 1'b0;
                r_sync_cnt <= r_sync_cnt + 1'b1;
                if (r_sync_cnt == SYNC_LAST) begin
                    r_state <= RUN;
                end
            end else begin
                r_active <= valid_in;
            end
        end else begin
            r_bit_cnt     <= r_bit_cnt + 1'b1;
            r_frame_start <= 1'b0;
        end
    end

    par2serial_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk        (clk_32f),
        .rst        (reset),
        .i_load     (w_load),
        .i_din      (w_next_byte),
        .o_dout_msb (data_out)
    );

    assign frame_start = r_frame_start;
    assign active      = r_active;

`ifdef P2S_ERR_CHK_EN
    logic [DATA_W-1:0] r_data_q;
    logic              r_valid_q;
    logic              r_err_align;

    // Upstream may only change its byte in the cycle that ends on a load edge
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_data_q    <= '0;
            r_valid_q   <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            r_data_q  <= data_in;
            r_valid_q <= valid_in;
            if (r_state == RUN && !w_load &&
                ((data_in != r_data_q) || (valid_in != r_valid_q))) begin
                r_err_align <= 1'b1;
            end
        end
    end

    assign err_align = r_err_align;
`endif

endmodule
`default_nettype wire

// File: tb/tb_par2serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_par2serial_tx
// Purpose  : Directed self-checking bench for par2serial_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_par2serial_tx;

    logic       clk_32f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       frame_start;
    logic       active;
`ifdef P2S_ERR_CHK_EN
    logic       err_align;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] bits;
    logic [7:0] act;
    logic [7:0] fs;

    par2serial_tx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .frame_start (frame_start),
        .active      (active)
`ifdef P2S_ERR_CHK_EN
        ,
        .err_align   (err_align)
`endif
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Presents one byte ahead of a load edge and captures the 8 serial cycles
    task automatic run_byte(input logic [7:0] d, input logic v,
                            output logic [7:0] ob, output logic [7:0] oa,
                            output logic [7:0] of);
        data_in  = d;
        valid_in = v;
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk_32f);
            #1;
            ob[i] = data_out;
            oa[i] = active;
            of[i] = frame_start;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        data_in  = 8'hA5;
        valid_in = 1'b1;
        repeat (3) @(posedge clk_32f);
        #1;
        n_tests++;
        if (data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data_out: got %b expected 0", data_out);
        end
        n_tests++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_start: got %b expected 0", frame_start);
        end
        n_tests++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_active: got %b expected 0", active);
        end
`ifdef P2S_ERR_CHK_EN
        n_tests++;
        if (err_align !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err_align: got %b expected 0", err_align);
        end
`endif
    endtask

    task automatic test_sync_then_payload();
        logic [7:0] exp_b;
        logic [7:0] exp_a;
        @(negedge clk_32f);
        reset = 1'b0;
        for (int b = 0; b < 5; b++) begin
            run_byte(8'hA5, 1'b1, bits, act, fs);
            exp_b = (b < 4) ? 8'hBC : 8'hA5;
            exp_a = (b < 4) ? 8'h00 : 8'hFF;
            n_tests++;
            if (bits !== exp_b) begin
                n_fail++;
                $display("FAIL sync_bits[%0d]: got %b expected %b", b, bits, exp_b);
            end
            n_tests++;
            if (act !== exp_a) begin
                n_fail++;
                $display("FAIL sync_active[%0d]: got %b expected %b", b, act, exp_a);
            end
            n_tests++;
            if (fs !== 8'h80) begin
                n_fail++;
                $display("FAIL sync_frame_start[%0d]: got %b expected 10000000", b, fs);
            end
        end
    endtask

    task automatic test_idle_gap();
        logic [7:0] d  [3] = '{8'h3C, 8'h00, 8'hC3};
        logic       v  [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] eb [3] = '{8'h3C, 8'hBC, 8'hC3};
        logic [7:0] ea [3] = '{8'hFF, 8'h00, 8'hFF};
        for (int b = 0; b < 3; b++) begin
            run_byte(d[b], v[b], bits, act, fs);
            n_tests++;
            if (bits !== eb[b]) begin
                n_fail++;
                $display("FAIL gap_bits[%0d]: got %b expected %b", b, bits, eb[b]);
            end
            n_tests++;
            if (act !== ea[b]) begin
                n_fail++;
                $display("FAIL gap_active[%0d]: got %b expected %b", b, act, ea[b]);
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] exp_b;
        logic [7:0] exp_a;
        data_in  = 8'h5A;
        valid_in = 1'b1;
        repeat (5) @(posedge clk_32f);
        #1;
        n_tests++;
        if (data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_bit3: got %b expected 1", data_out);
        end
        @(negedge clk_32f);
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        n_tests++;
        if (data_out !== 1'b0 || frame_start !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got d=%b fs=%b act=%b expected 0 0 0",
                     data_out, frame_start, active);
        end
        @(negedge clk_32f);
        reset = 1'b0;
        for (int b = 0; b < 5; b++) begin
            run_byte(8'h5A, 1'b1, bits, act, fs);
            exp_b = (b < 4) ? 8'hBC : 8'h5A;
            exp_a = (b < 4) ? 8'h00 : 8'hFF;
            n_tests++;
            if (bits !== exp_b || act !== exp_a || fs !== 8'h80) begin
                n_fail++;
                $display("FAIL midrst_resync[%0d]: got bits=%b act=%b fs=%b expected %b %b 10000000",
                         b, bits, act, fs, exp_b, exp_a);
            end
        end
    endtask

    task automatic test_frame_spacing();
        int cnt  = 0;
        int last = 0;
        int bad  = 0;
        @(negedge clk_32f);
        reset = 1'b1;
        @(posedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk_32f);
            #1;
            if (frame_start === 1'b1) begin
                if ((cnt == 0 && i != 0) || (cnt > 0 && (i - last) != 8)) bad++;
                cnt++;
                last = i;
            end
        end
        n_tests++;
        if (cnt != 10) begin
            n_fail++;
            $display("FAIL fs_count: got %0d expected 10", cnt);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fs_spacing: got %0d misplaced pulses expected 0", bad);
        end
    endtask

    task automatic test_idle_payload();
        logic [7:0] d  [3] = '{8'h00, 8'hBC, 8'h00};
        logic       v  [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] ea [3] = '{8'h00, 8'hFF, 8'h00};
        for (int b = 0; b < 3; b++) begin
            run_byte(d[b], v[b], bits, act, fs);
            n_tests++;
            if (bits !== 8'hBC) begin
                n_fail++;
                $display("FAIL idlepay_bits[%0d]: got %b expected 10111100", b, bits);
            end
            n_tests++;
            if (act !== ea[b]) begin
                n_fail++;
                $display("FAIL idlepay_active[%0d]: got %b expected %b", b, act, ea[b]);
            end
        end
    endtask

`ifdef P2S_ERR_CHK_EN
    task automatic test_err_align();
        n_tests++;
        if (err_align !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clean: got %b expected 0", err_align);
        end
        data_in  = 8'h11;
        valid_in = 1'b1;
        repeat (3) @(posedge clk_32f);
        #1;
        data_in = 8'h22;
        @(posedge clk_32f);
        #1;
        n_tests++;
        if (err_align !== 1'b1) begin
            n_fail++;
            $display("FAIL err_rise: got %b expected 1", err_align);
        end
        repeat (4) @(posedge clk_32f);
        run_byte(8'h33, 1'b1, bits, act, fs);
        n_tests++;
        if (err_align !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", err_align);
        end
        @(negedge clk_32f);
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        n_tests++;
        if (err_align !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b expected 0", err_align);
        end
        @(negedge clk_32f);
        reset = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sync_then_payload();
        test_idle_gap();
        test_reset_mid_byte();
        test_frame_spacing();
        test_idle_payload();
`ifdef P2S_ERR_CHK_EN
        test_err_align();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
